// File: rtl/mul_sum.sv
// mul_sum: sequential 8x8 unsigned shift-and-add multiplier.
// The accumulating adder lives in its own combinational block (sum) and is
// reached through an operand/result port triplet so it can be shared or swapped.

// sum: 16-bit combinational adder, result wraps modulo 2^16.
module sum (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);

  assign result = a + b;

endmodule

// mul: control and datapath for the shift-and-add multiplication.
module mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] result,
  output logic        busy,
  output logic [15:0] sum_in_a,
  output logic [15:0] sum_in_b,
  input  logic [15:0] sum_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;     // multiplicand, zero-extended so shifts stay in range
  logic [7:0]  b_q, b_d;     // multiplier, one bit consumed per step
  logic [2:0]  i_q, i_d;     // step index, also the shift amount
  logic [15:0] acc_q, acc_d; // running sum, doubles as the visible product

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 8'h00;
      i_q     <= 3'd0;
      acc_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic and adder operand selection.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    i_d      = i_q;
    acc_d    = acc_q;
    sum_in_a = acc_q;
    sum_in_b = 16'h0000;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {8'h00, a_i};
          b_d     = b_i;
          acc_d   = 16'h0000;
          i_d     = 3'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Partial product is the shifted multiplicand when the current multiplier bit is set.
        if (b_q[i_q]) begin
          sum_in_b = a_q << i_q;
        end else begin
          sum_in_b = 16'h0000;
        end
        acc_d = sum_out;
        if (i_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          i_d = i_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result = acc_q;
  assign busy   = (state_q == RUN);

endmodule

// mul_sum: top wrapper connecting the multiplier core to its adder.
module mul_sum (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] result,
  output logic        busy
);

  logic [15:0] sum_in_a_s;
  logic [15:0] sum_in_b_s;
  logic [15:0] sum_out_s;

  mul u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_i      (a_i),
    .b_i      (b_i),
    .result   (result),
    .busy     (busy),
    .sum_in_a (sum_in_a_s),
    .sum_in_b (sum_in_b_s),
    .sum_out  (sum_out_s)
  );

  sum u_sum (
    .a      (sum_in_a_s),
    .b      (sum_in_b_s),
    .result (sum_out_s)
  );

endmodule

// File: tb/tb_mul_sum.sv
// Self-checking bench for mul_sum: table-driven operations with a result
// scoreboard, plus hand-written sequences for abort, held start and the adder.
module tb_mul_sum;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic [15:0] result;
  logic        busy;

  logic [15:0] sa, sb, sr;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  mul_sum dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_i    (a_i),
    .b_i    (b_i),
    .result (result),
    .busy   (busy)
  );

  sum u_sum_alone (
    .a      (sa),
    .b      (sb),
    .result (sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait out a busy period, counting cycles with busy high; bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, result %0d", name, result);
    end else begin
      e = exp_q.pop_front();
      check(name, {16'h0000, result}, {16'h0000, e});
    end
  endtask

  // One operation; inj>0 pulses start with junk operands on that busy cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int inj, input string name);
    int cnt;
    @(negedge clk);
    a_i = a;
    b_i = b;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      if (inj != 0 && cnt == inj) begin
        a_i = ~a;
        b_i = 8'd200;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_latency"}, cnt, 8);
    pop_check({name, "_result"});
  endtask

  initial begin
    int cnt;
    vecs[0] = '{a: 8'd3,   b: 8'd2,   exp: 16'd6};
    vecs[1] = '{a: 8'd5,   b: 8'd5,   exp: 16'd25};
    vecs[2] = '{a: 8'd4,   b: 8'd3,   exp: 16'd12};
    vecs[3] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
    vecs[4] = '{a: 8'd255, b: 8'd0,   exp: 16'd0};
    vecs[5] = '{a: 8'd0,   b: 8'd37,  exp: 16'd0};
    vecs[6] = '{a: 8'd1,   b: 8'd255, exp: 16'd255};
    vecs[7] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};

    rst = 1'b0;
    start = 1'b0;
    a_i = 8'd0;
    b_i = 8'd0;
    sa = 16'h0000;
    sb = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", {16'h0000, result}, 32'd0);

    // Table-driven operations.
    for (int k = 0; k < 8; k++) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].exp, 0, $sformatf("vec%0d", k));
    end

    // Result holds while idle.
    repeat (3) @(negedge clk);
    check("result_hold", {16'h0000, result}, 32'd256);

    // Start and operand changes mid-run are ignored.
    run_op(8'd7, 8'd9, 16'd63, 3, "midrun_ignore");

    // Asynchronous reset mid-run, checked before any clock edge.
    @(negedge clk);
    a_i = 8'd200;
    b_i = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {16'h0000, result}, 32'd0);
    // Start is ignored while reset is held.
    start = 1'b1;
    @(negedge clk);
    check("reset_start_ignored", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b1;
    run_op(8'd200, 8'd100, 16'd20000, 0, "after_abort");

    // Start held high: back-to-back operations.
    @(negedge clk);
    a_i = 8'd3;
    b_i = 8'd4;
    start = 1'b1;
    exp_q.push_back(16'd12);
    @(negedge clk);
    wait_done(cnt);
    check("b2b_first_latency", cnt, 8);
    pop_check("b2b_first_result");
    a_i = 8'd6;
    b_i = 8'd7;
    exp_q.push_back(16'd42);
    @(negedge clk);
    start = 1'b0;
    check("b2b_restart_busy", {31'd0, busy}, 32'd1);
    wait_done(cnt);
    check("b2b_second_latency", cnt, 8);
    pop_check("b2b_second_result");

    // Standalone adder.
    sa = 16'hFFFF;
    sb = 16'h0001;
    #1;
    check("sum_wrap", {16'h0000, sr}, 32'd0);
    sa = 16'd1234;
    sb = 16'd4321;
    #1;
    check("sum_plain", {16'h0000, sr}, 32'd5555);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
